rx_serial_7e1: RTL



---
 rtl/rx_serial_pkg.sv | 21 ++
 rtl/rx_serial_7e1_gerador_tick.sv | 29 ++
 rtl/rx_serial_7e1.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rx_serial_pkg.sv
// Shared types and constants for the 7E1 serial receiver.
// Holds the FSM encoding, the data width and the tick divider calculation.
package rx_serial_pkg;

  localparam int DATA_W = 7;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    DADOS       = 3'd2,
    PARIDADE    = 3'd3,
    STOP        = 3'd4,
    ESPERA_ALTO = 3'd5
  } state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/rx_serial_7e1_gerador_tick.sv
// Oversample tick divider: down-counter with terminal-count tick and synchronous restart.
// Restart reloads the counter so the first tick lands DIV clocks later.
module gerador_tick #(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver, 16x oversampled, with one-entry output register.
// Optional RX_FILTER_EN: 3-sample majority vote per bit instead of a single mid-bit sample.
//
// state       | meaning
// IDLE        | line idle, waiting for a low level
// START       | inside start bit, glitch check at mid-bit
// DADOS       | receiving 7 data bits, LSB first
// PARIDADE    | receiving parity bit
// STOP        | receiving stop bit, frame committed at mid-bit
// ESPERA_ALTO | stop bit was low, wait for the line to return high
module rx_serial_7e1
  import rx_serial_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RX,
  input  logic              recebido,
  output logic [DATA_W-1:0] dados,
  output logic              dado_valido,
  output logic              erro_paridade,
  output logic              erro_stop,
  output logic              overrun,
  output logic              ocupado
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_W - 1);

  state_t state, state_nx;

  logic              rx_s1, rx_s2, rx_sync;
  logic              tick, restart;
  logic [SW-1:0]     samp_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_err;
  logic              take, val, bit_end;
  logic              shift_en, par_load, commit;

  assign rx_sync = rx_s2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
    end
  end

  gerador_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign bit_end = tick && (samp_cnt == LAST);

`ifdef RX_FILTER_EN
  localparam logic [SW-1:0] V0_AT   = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] VOTE_AT = SW'(OVERSAMPLE / 2);

  logic v0, v1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else if (tick) begin
      if (samp_cnt == V0_AT) v0 <= rx_sync;
      if (samp_cnt == MID)   v1 <= rx_sync;
    end
  end

  assign take = tick && (samp_cnt == VOTE_AT);
  assign val  = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
`else
  assign take = tick && (samp_cnt == MID);
  assign val  = rx_sync;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    shift_en = 1'b0;
    par_load = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_nx = START;
          restart  = 1'b1;
        end
      end
      START: begin
        if (take && val) state_nx = IDLE;
        else if (bit_end) state_nx = DADOS;
      end
      DADOS: begin
        shift_en = take;
        if (bit_end && bit_idx == LAST_BIT) state_nx = PARIDADE;
      end
      PARIDADE: begin
        par_load = take;
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (take) begin
          commit   = 1'b1;
          state_nx = val ? IDLE : ESPERA_ALTO;
        end
      end
      ESPERA_ALTO: begin
        if (rx_sync) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      samp_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
    end else begin
      if (restart) samp_cnt <= '0;
      else if (tick && state != IDLE) samp_cnt <= samp_cnt + 1'b1;

      if (restart) bit_idx <= '0;
      else if (state == DADOS && bit_end) bit_idx <= bit_idx + 1'b1;

      if (shift_en) shreg <= {val, shreg[DATA_W-1:1]};

      // Expected parity bit: XOR of data for even, its complement for odd.
      if (par_load) par_err <= val ^ ((PARITY_ODD != 0) ? ~^shreg : ^shreg);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados         <= '0;
      dado_valido   <= 1'b0;
      erro_paridade <= 1'b0;
      erro_stop     <= 1'b0;
      overrun       <= 1'b0;
    end else if (commit) begin
      dados         <= shreg;
      erro_paridade <= par_err;
      erro_stop     <= !val;
      dado_valido   <= 1'b1;
      if (dado_valido && !recebido) overrun <= 1'b1;
      else if (dado_valido && recebido) overrun <= 1'b0;
    end else if (recebido && dado_valido) begin
      dado_valido <= 1'b0;
      overrun     <= 1'b0;
    end
  end

  assign ocupado = (state != IDLE);

endmodule
